// File: rtl/ub_host_reader.sv
// ub_host_reader: host readback engine for the unified buffer.
// Accepts one read command (base, rows, cols), walks the UB read port and
// streams each element to the host through a small first-word-fall-through
// prefetch FIFO guarded by a credit check, so returning data is never dropped.
// Optional feature macro: UB_HOST_READER_TRANSPOSE_EN enables the column-major
// walk selected by cmd_transpose; without it the walk is always row-major.
// FIFO_DEPTH must be a power of two and at least 2.
module ub_host_reader #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int DATA_WIDTH           = 16,
  parameter int ADDR_WIDTH           = 16,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_row_size,
  input  logic [15:0]           cmd_col_size,
  input  logic                  cmd_transpose,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] host_data_out,
  output logic                  host_valid_out,
  input  logic                  host_ready_in,
  output logic                  host_last_out,
  output logic                  done_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]         PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  // Array geometry is carried for consistency with the rest of the UB only.
  localparam int unused_geometry = SYSTOLIC_ARRAY_WIDTH;

  logic [1:0]            state;
  logic [31:0]           total;
  logic [31:0]           issued;
  logic [31:0]           total_calc;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  mem_rd_last;
  logic                  land;
  logic                  land_last;
  logic                  pop;
  logic                  can_issue;
  logic                  last_issue;
  logic [CW-1:0]         outstanding;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

`ifdef UB_HOST_READER_TRANSPOSE_EN
  logic                  xpose;
  logic [15:0]           rows;
  logic [15:0]           cols;
  logic [15:0]           col_idx;
  logic [ADDR_WIDTH-1:0] row_start;
`else
  logic unused_transpose;
  assign unused_transpose = cmd_transpose;
`endif

  assign total_calc = 32'(cmd_row_size) * 32'(cmd_col_size);
  assign last_issue = (issued == (total - 32'd1));

  assign pop            = host_valid_out & host_ready_in;
  assign host_valid_out = (count != {(PW+1){1'b0}});
  assign host_data_out  = fifo_data[rd_ptr];
  assign host_last_out  = host_valid_out & fifo_last[rd_ptr];
  assign cmd_ready      = rst & (state == S_IDLE);

  // Everything already stored or still on its way must fit in the FIFO,
  // counting the slot freed by a pop at this same edge.
  assign outstanding = CW'(count) + CW'(mem_rd_en) + CW'(land) - CW'(pop);
  assign can_issue   = (outstanding < CW'(FIFO_DEPTH));

  // Address of the next read, derived from the address just issued.
  always_comb begin
    next_addr = mem_rd_addr + ADDR_ONE;
`ifdef UB_HOST_READER_TRANSPOSE_EN
    if (xpose) begin
      if (col_idx == (cols - 16'd1)) begin
        next_addr = row_start + ADDR_ONE;
      end else begin
        next_addr = mem_rd_addr + ADDR_WIDTH'(rows);
      end
    end else begin
      next_addr = mem_rd_addr + ADDR_ONE;
    end
`endif
  end

  // Command FSM: accept, issue reads under credit, then wait for the last handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      total       <= 32'd0;
      issued      <= 32'd0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= {ADDR_WIDTH{1'b0}};
      mem_rd_last <= 1'b0;
      land        <= 1'b0;
      land_last   <= 1'b0;
      done_out    <= 1'b0;
`ifdef UB_HOST_READER_TRANSPOSE_EN
      xpose       <= 1'b0;
      rows        <= 16'd0;
      cols        <= 16'd0;
      col_idx     <= 16'd0;
      row_start   <= {ADDR_WIDTH{1'b0}};
`endif
    end else begin
      land        <= mem_rd_en;
      land_last   <= mem_rd_en & mem_rd_last;
      mem_rd_en   <= 1'b0;
      mem_rd_last <= 1'b0;
      done_out    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            total <= total_calc;
            if (total_calc == 32'd0) begin
              done_out <= 1'b1;
            end else begin
              // The first read goes out straight from the accept edge.
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= cmd_addr;
              mem_rd_last <= (total_calc == 32'd1);
              issued      <= 32'd1;
              state       <= (total_calc == 32'd1) ? S_DRAIN : S_ISSUE;
            end
`ifdef UB_HOST_READER_TRANSPOSE_EN
            xpose     <= cmd_transpose;
            rows      <= cmd_row_size;
            cols      <= cmd_col_size;
            col_idx   <= 16'd0;
            row_start <= cmd_addr;
`endif
          end
        end
        S_ISSUE: begin
          if (can_issue) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= next_addr;
            mem_rd_last <= last_issue;
            issued      <= issued + 32'd1;
            if (last_issue) begin
              state <= S_DRAIN;
            end
`ifdef UB_HOST_READER_TRANSPOSE_EN
            if (col_idx == (cols - 16'd1)) begin
              col_idx   <= 16'd0;
              row_start <= row_start + ADDR_ONE;
            end else begin
              col_idx <= col_idx + 16'd1;
            end
`endif
          end
        end
        S_DRAIN: begin
          // The last element leaving implies the FIFO is empty and nothing is in flight.
          if (done_out) begin
            state <= S_IDLE;
          end else if (pop && host_last_out) begin
            done_out <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Prefetch FIFO: data lands one cycle after each strobe, the host pops the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= {DATA_WIDTH{1'b0}};
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {(PW+1){1'b0}};
    end else begin
      if (land) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_last[wr_ptr] <= land_last;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count + (PW+1)'(land) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_ub_host_reader.sv
// Scoreboard bench for ub_host_reader: stimulus pushes expected reads and
// elements into queues, a monitor on the falling edge pops and compares.
`timescale 1ns/1ps
module tb_ub_host_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_row_size;
  logic [15:0] cmd_col_size;
  logic        cmd_transpose;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data = 16'h0000;
  logic [15:0] host_data_out;
  logic        host_valid_out;
  logic        host_ready_in;
  logic        host_last_out;
  logic        done_out;

  ub_host_reader #(
    .SYSTOLIC_ARRAY_WIDTH(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_row_size(cmd_row_size), .cmd_col_size(cmd_col_size), .cmd_transpose(cmd_transpose),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .host_data_out(host_data_out), .host_valid_out(host_valid_out), .host_ready_in(host_ready_in),
    .host_last_out(host_last_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // UB model: every location holds its own address, returned one cycle after the strobe.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_rd_addr : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total_n = 0;
  int          bad_n = 0;
  logic [16:0] exp_data[$];
  logic [15:0] exp_addr[$];
  int          done_cnt = 0;
  int          exp_done_cyc = -10;
  int          acc_cyc = 0;
  int          issued_n = 0;
  int          popped_n = 0;
  int          last_hs_cyc = 0;
  bit          rd_chk = 0, val_chk = 0, zero_cmd = 0, credit_chk = 0, consec_chk = 0;
  bit          hs_seen = 0, prev_stall = 0, prev_done = 0, prev_zero = 0;
  logic [16:0] prev_head = 17'h0;
  int          rp_mode = 0;
  logic [3:0]  rp_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_elem(input logic [15:0] a, input logic last);
    exp_addr.push_back(a);
    exp_data.push_back({last, a});
  endtask

  task automatic check_quiet_outputs(input logic ready_exp);
    check("q_cmd_ready", cmd_ready, ready_exp);
    check("q_mem_rd_en", mem_rd_en, 1'b0);
    check("q_mem_rd_addr", mem_rd_addr, 16'h0000);
    check("q_host_data", host_data_out, 16'h0000);
    check("q_host_valid", host_valid_out, 1'b0);
    check("q_host_last", host_last_out, 1'b0);
    check("q_done", done_out, 1'b0);
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] r, input logic [15:0] c, input logic xp);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    zero_cmd      = (r == 16'd0) || (c == 16'd0);
    cmd_valid     = 1'b1;
    cmd_addr      = a;
    cmd_row_size  = r;
    cmd_col_size  = c;
    cmd_transpose = xp;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    hs_seen   = 0;
    if (zero_cmd) begin
      exp_done_cyc = acc_cyc;
    end else begin
      rd_chk  = 1;
      val_chk = 1;
    end
  endtask

  task automatic wait_done(input int start, input int budget);
    int w = 0;
    while (done_cnt == start && w < budget) begin
      @(posedge clk); #2;
      w++;
    end
    check("done_seen", done_cnt, start + 1);
    check("elems_left", exp_data.size(), 0);
    check("reads_left", exp_addr.size(), 0);
  endtask

  // Host ready driver: always ready, or the repeating 1,0,0,1 pattern.
  initial begin
    host_ready_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      host_ready_in = (rp_mode == 0) ? 1'b1 : rp_pat[cyc % 4];
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      if (mem_rd_en) begin
        issued_n++;
        if (rd_chk) begin
          check("rd_latency", cyc, acc_cyc);
          rd_chk = 0;
        end
        if (exp_addr.size() > 0) e = {16'h0, exp_addr.pop_front()};
        else e = 'x;
        check("rd_addr", {16'h0, mem_rd_addr}, e);
      end
      if (credit_chk) check("credit_bound", ((issued_n - popped_n) <= DEPTH), 1'b1);
      if (prev_stall) begin
        check("stall_valid", host_valid_out, 1'b1);
        check("stall_hold", {host_last_out, host_data_out}, prev_head);
      end
      if (host_valid_out) begin
        if (val_chk) begin
          check("valid_latency", cyc, acc_cyc + 2);
          val_chk = 0;
        end
        if (host_ready_in) begin
          if (exp_data.size() > 0) e = {15'h0, exp_data.pop_front()};
          else e = 'x;
          check("elem", {15'h0, host_last_out, host_data_out}, e);
          if (consec_chk && hs_seen) check("consecutive", cyc, last_hs_cyc + 1);
          hs_seen     = 1;
          last_hs_cyc = cyc;
          popped_n++;
          if (host_last_out) exp_done_cyc = cyc + 1;
        end
      end
      prev_stall = host_valid_out && !host_ready_in;
      prev_head  = {host_last_out, host_data_out};
      if (prev_done && !prev_zero) check("ready_after_done", cmd_ready, 1'b1);
      if (done_out) begin
        done_cnt++;
        check("done_pulse_width", prev_done, 1'b0);
        check("done_timing", cyc, exp_done_cyc);
        check("ready_during_done", cmd_ready, zero_cmd);
        prev_zero = zero_cmd;
      end
      prev_done = done_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int pop0;
    int iss0;
    int w;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = 16'h0; cmd_row_size = 16'h0;
    cmd_col_size = 16'h0; cmd_transpose = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    // Row-major 2x3 at 0x0010, host always ready.
    for (int i = 0; i < 6; i++) expect_elem(16'h0010 + 16'(i), i == 5);
    consec_chk = 1;
    start = done_cnt;
    send_cmd(16'h0010, 16'd2, 16'd3, 1'b0);
    wait_done(start, 100);
    consec_chk = 0;

    // Backpressure 1x8 with ready toggling 1,0,0,1.
    for (int i = 0; i < 8; i++) expect_elem(16'h0040 + 16'(i), i == 7);
    rp_mode = 1; credit_chk = 1;
    start = done_cnt;
    send_cmd(16'h0040, 16'd1, 16'd8, 1'b0);
    wait_done(start, 200);
    rp_mode = 0; credit_chk = 0;

    // 2x2 transposed request at 0.
`ifdef UB_HOST_READER_TRANSPOSE_EN
    expect_elem(16'h0000, 1'b0); expect_elem(16'h0002, 1'b0);
    expect_elem(16'h0001, 1'b0); expect_elem(16'h0003, 1'b1);
`else
    expect_elem(16'h0000, 1'b0); expect_elem(16'h0001, 1'b0);
    expect_elem(16'h0002, 1'b0); expect_elem(16'h0003, 1'b1);
`endif
    start = done_cnt;
    send_cmd(16'h0000, 16'd2, 16'd2, 1'b1);
    wait_done(start, 100);

    // Address wrap 1x4 from 0xFFFE.
    expect_elem(16'hFFFE, 1'b0); expect_elem(16'hFFFF, 1'b0);
    expect_elem(16'h0000, 1'b0); expect_elem(16'h0001, 1'b1);
    start = done_cnt;
    send_cmd(16'hFFFE, 16'd1, 16'd4, 1'b0);
    wait_done(start, 100);

    // Zero-size 0x5: no reads, done one cycle after accept.
    iss0  = issued_n;
    start = done_cnt;
    send_cmd(16'h0123, 16'd0, 16'd5, 1'b0);
    wait_done(start, 20);
    repeat (3) @(posedge clk);
    #1;
    check("zero_no_reads", issued_n, iss0);

    // Reset in the middle of a 1x8 read after two elements.
    for (int i = 0; i < 8; i++) expect_elem(16'h0100 + 16'(i), i == 7);
    pop0  = popped_n;
    start = done_cnt;
    send_cmd(16'h0100, 16'd1, 16'd8, 1'b0);
    w = 0;
    while (popped_n < pop0 + 2 && w < 50) begin
      @(posedge clk); #2;
      w++;
    end
    check("two_elems_before_reset", popped_n, pop0 + 2);
    rst = 1'b0;
    #1;
    check_quiet_outputs(1'b0);
    exp_data.delete(); exp_addr.delete();
    rd_chk = 0; val_chk = 0; prev_stall = 0; prev_done = 0;
    issued_n = 0; popped_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs(1'b0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, start);
    check_quiet_outputs(1'b1);
    expect_elem(16'h0200, 1'b0); expect_elem(16'h0201, 1'b1);
    start = done_cnt;
    send_cmd(16'h0200, 16'd1, 16'd2, 1'b0);
    wait_done(start, 100);
    repeat (4) @(posedge clk);
    #1;
    check("final_done_count", done_cnt, start + 1);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
